// File: rtl/jtframe_pocket_dwnld.sv
// Buffered APF bridge to ioctl download unpacker: bridge words are queued in a
// small FIFO and serialised into DW-bit beats paced by the loader's prog_rdy.
module jtframe_pocket_dwnld #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 25,
  parameter int unsigned SWAP  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_wr,
  input  logic [31:0]   br_addr,
  input  logic [31:0]   br_data,
  input  logic [7:0]    slot_id,
  input  logic          slot_done,
  input  logic          prog_rdy,
  output logic [AW-1:0] ioctl_addr,
  output logic [DW-1:0] ioctl_dout,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic          downloading,
  output logic          full,
  output logic          overflow
);

  localparam int unsigned BEATS = 32 / DW;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned EW    = 8 + AW + 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [7:0]    index_q, index_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          wr_q, wr_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          dl_q, dl_d;
  logic          done_pend_q, done_pend_d;
  logic          cmd_space, push, pop, empty, dl_clear;
  logic [EW-1:0] head;

  // FIFO storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {slot_id, br_addr[AW-1:0], br_data};
  end

  // Next-state: FIFO pointers, serialiser FSM and status flags
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    addr_d      = addr_q;
    index_d     = index_q;
    beat_d      = beat_q;
    dl_d        = dl_q;
    done_pend_d = done_pend_q | slot_done;
    pop         = 1'b0;

    cmd_space = (br_addr[31:24] == 8'hF8);
    push      = br_wr && !cmd_space && !full_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    head      = mem_q[rd_ptr_q[PW-1:0]];

    case (state_q)
      IDLE: begin
        if (!empty) begin
          data_d  = head[31:0];
          addr_d  = head[AW+31:32];
          index_d = head[EW-1 -: 8];
          beat_d  = '0;
          pop     = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: state_d = WAIT;
      WAIT: begin
        if (prog_rdy) begin
          if (beat_q != BW'(BEATS - 1)) begin
            beat_d  = beat_q + BW'(1);
            addr_d  = addr_q + AW'(DW / 8);
            data_d  = (SWAP != 0) ? (data_q << DW) : (data_q >> DW);
            state_d = EMIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PW + 1)'(pop);
    full_d   = (wr_ptr_d[PW] != rd_ptr_d[PW]) && (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    ovf_d    = ovf_q | (br_wr && !cmd_space && full_q);
    dout_d   = (SWAP != 0) ? data_d[31 -: DW] : data_d[DW-1:0];
    wr_d     = (state_d == EMIT);

    // Download ends only once everything queued has been handed to the loader
    dl_clear = done_pend_q && empty && (state_q == IDLE) && !push;
    if (dl_clear) begin
      dl_d        = 1'b0;
      done_pend_d = 1'b0;
    end
    if (push) dl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      data_q      <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      index_q     <= '0;
      beat_q      <= '0;
      wr_q        <= 1'b0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dl_q        <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      index_q     <= index_d;
      beat_q      <= beat_d;
      wr_q        <= wr_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      dl_q        <= dl_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign ioctl_addr  = addr_q;
  assign ioctl_dout  = dout_q;
  assign ioctl_index = index_q;
  assign ioctl_wr    = wr_q;
  assign downloading = dl_q;
  assign full        = full_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Scoreboard bench for jtframe_pocket_dwnld: an 8-bit LSB-first instance and a
// 16-bit MSB-first instance, directed vectors with hand-computed beats.
module tb_jtframe_pocket_dwnld;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
    logic [7:0]  x;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, br_wr8, br_wr16, slot_done, prog_rdy8, prog_rdy16;
  logic [31:0] br_addr, br_data;
  logic [7:0]  slot_id;
  logic [24:0] a8, a16;
  logic [7:0]  d8, x8, x16;
  logic [15:0] d16;
  logic        wr8, dl8, full8, ovf8, wr16, dl16, full16, ovf16;

  int    checks = 0, failures = 0, cyc = 0;
  int    wr_cnt8 = 0, last_wr8 = 0, first_wr8 = -1, push_cyc8 = 0;
  bit    rdy_en = 1'b1;
  beat_t q8[$], q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtframe_pocket_dwnld #(.DW(8), .DEPTH(4), .AW(25), .SWAP(0)) u8 (
    .clk(clk), .rst(rst), .br_wr(br_wr8), .br_addr(br_addr), .br_data(br_data),
    .slot_id(slot_id), .slot_done(slot_done), .prog_rdy(prog_rdy8),
    .ioctl_addr(a8), .ioctl_dout(d8), .ioctl_index(x8), .ioctl_wr(wr8),
    .downloading(dl8), .full(full8), .overflow(ovf8));

  jtframe_pocket_dwnld #(.DW(16), .DEPTH(4), .AW(25), .SWAP(1)) u16 (
    .clk(clk), .rst(rst), .br_wr(br_wr16), .br_addr(br_addr), .br_data(br_data),
    .slot_id(slot_id), .slot_done(slot_done), .prog_rdy(prog_rdy16),
    .ioctl_addr(a16), .ioctl_dout(d16), .ioctl_index(x16), .ioctl_wr(wr16),
    .downloading(dl16), .full(full16), .overflow(ovf16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Scoreboard monitors: every beat strobe pops one expected beat
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (wr8 === 1'b1) begin
      wr_cnt8++;
      last_wr8 = cyc;
      if (first_wr8 < 0) first_wr8 = cyc;
      if (q8.size() == 0) fail_now("wr8_unexpected");
      else begin
        e = q8.pop_front();
        chk("wr8_addr", 32'(a8), 32'(e.a));
        chk("wr8_data", 32'(d8), 32'(e.d[7:0]));
        chk("wr8_index", 32'(x8), 32'(e.x));
      end
    end
  end

  initial forever begin
    beat_t e;
    @(negedge clk);
    if (wr16 === 1'b1) begin
      if (q16.size() == 0) fail_now("wr16_unexpected");
      else begin
        e = q16.pop_front();
        chk("wr16_addr", 32'(a16), 32'(e.a));
        chk("wr16_data", 32'(d16), 32'(e.d));
        chk("wr16_index", 32'(x16), 32'(e.x));
      end
    end
  end

  // Loader model for the 8-bit instance: prog_rdy 3 cycles after each beat
  initial begin : resp8
    bit pend;
    int cnt;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      prog_rdy8 = 1'b0;
      if (rst) begin
        pend = 1'b0;
        cnt  = 0;
      end else if (wr8) begin
        pend = 1'b1;
        cnt  = 3;
      end else if (pend && rdy_en) begin
        cnt--;
        if (cnt == 0) begin
          prog_rdy8 = 1'b1;
          pend      = 1'b0;
        end
      end
    end
  end

  task automatic push8(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] idx);
    push_cyc8 = cyc;
    br_addr = addr;
    br_data = data;
    slot_id = idx;
    br_wr8  = 1'b1;
    @(negedge clk);
    br_wr8  = 1'b0;
  endtask

  task automatic exp8(input logic [24:0] addr, input logic [31:0] data, input logic [7:0] idx);
    for (int b = 0; b < 4; b++)
      q8.push_back('{a: addr + 25'(b), d: {8'h00, data[8*b +: 8]}, x: idx});
  endtask

  task automatic check_reset8(input string tag);
    chk({tag, "_wr"}, 32'(wr8), 32'd0);
    chk({tag, "_downloading"}, 32'(dl8), 32'd0);
    chk({tag, "_full"}, 32'(full8), 32'd0);
    chk({tag, "_overflow"}, 32'(ovf8), 32'd0);
    chk({tag, "_addr"}, 32'(a8), 32'd0);
    chk({tag, "_dout"}, 32'(d8), 32'd0);
    chk({tag, "_index"}, 32'(x8), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q8.delete();
    q16.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain8(input string name);
    int n = 0;
    while (q8.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) fail_now(name);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n, base, p;
    bit dl_drop;
    rst = 1'b1; br_wr8 = 1'b0; br_wr16 = 1'b0; slot_done = 1'b0;
    prog_rdy16 = 1'b0; br_addr = '0; br_data = '0; slot_id = '0;
    repeat (3) @(negedge clk);
    check_reset8("rst_init");
    chk("rst_init_wr16", 32'(wr16), 32'd0);
    chk("rst_init_dout16", 32'(d16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Byte beats LSB first, first strobe two cycles after the push
    first_wr8 = -1;
    q8.push_back('{a: 25'h100, d: 16'h0011, x: 8'h00});
    q8.push_back('{a: 25'h101, d: 16'h0022, x: 8'h00});
    q8.push_back('{a: 25'h102, d: 16'h0033, x: 8'h00});
    q8.push_back('{a: 25'h103, d: 16'h0044, x: 8'h00});
    push8(32'h0000_0100, 32'h4433_2211, 8'h00);
    drain8("t1_drain");
    chk("t1_latency", 32'(first_wr8 - push_cyc8), 32'd2);
    chk("t1_beats", 32'(wr_cnt8), 32'd4);

    // Halfword beats MSB first on the 16-bit instance
    q16.push_back('{a: 25'h200, d: 16'hAABB, x: 8'h00});
    q16.push_back('{a: 25'h202, d: 16'hCCDD, x: 8'h00});
    br_addr = 32'h0000_0200; br_data = 32'hAABB_CCDD; slot_id = 8'h00;
    br_wr16 = 1'b1;
    @(negedge clk);
    br_wr16 = 1'b0;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!wr16 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) fail_now("t2_wr16_wait");
      repeat (3) @(negedge clk);
      prog_rdy16 = 1'b1;
      @(negedge clk);
      prog_rdy16 = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("t2_q16_left", 32'(q16.size()), 32'd0);

    // Overflow: one word parked in the serialiser, then six pushes into DEPTH=4
    rdy_en = 1'b0;
    exp8(25'h300, 32'h0D0C_0B0A, 8'h01);
    push8(32'h0000_0300, 32'h0D0C_0B0A, 8'h01);
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) exp8(25'(32'h400 + 16 * k), 32'h1111_1111 * k, 8'h01);
      push8(32'h400 + 16 * k, 32'h1111_1111 * k, 8'h01);
      if (k == 3) chk("t3_full_after3", 32'(full8), 32'd0);
      if (k == 4) begin
        chk("t3_full_after4", 32'(full8), 32'd1);
        chk("t3_ovf_after4", 32'(ovf8), 32'd0);
      end
    end
    chk("t3_overflow", 32'(ovf8), 32'd1);
    chk("t3_full_held", 32'(full8), 32'd1);
    rdy_en = 1'b1;
    drain8("t3_drain");
    chk("t3_full_drained", 32'(full8), 32'd0);
    chk("t3_overflow_sticky", 32'(ovf8), 32'd1);

    // Command-space write ignored; slot id tags the emitted word
    do_reset();
    chk("t4_overflow_cleared", 32'(ovf8), 32'd0);
    push8(32'hF800_0000, 32'hDEAD_BEEF, 8'h07);
    exp8(25'h500, 32'h8765_4321, 8'h03);
    push8(32'h0000_0500, 32'h8765_4321, 8'h03);
    drain8("t4_drain");
    chk("t4_overflow", 32'(ovf8), 32'd0);

    // downloading holds until the second word's last beat is consumed
    do_reset();
    exp8(25'h600, 32'h0403_0201, 8'h02);
    push8(32'h0000_0600, 32'h0403_0201, 8'h02);
    exp8(25'h604, 32'h0807_0605, 8'h02);
    push8(32'h0000_0604, 32'h0807_0605, 8'h02);
    chk("t5_dl_set", 32'(dl8), 32'd1);
    repeat (6) @(negedge clk);
    slot_done = 1'b1;
    @(negedge clk);
    slot_done = 1'b0;
    dl_drop = 1'b0;
    n = 0;
    while (!(q8.size() == 0 && cyc >= last_wr8 + 4) && n < 400) begin
      if (!dl8) dl_drop = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("t5_wait");
    chk("t5_dl_held", 32'(dl_drop), 32'd0);
    chk("t5_dl_before_fall", 32'(dl8), 32'd1);
    @(negedge clk);
    chk("t5_dl_fall", 32'(dl8), 32'd0);

    // Reset in the middle of a word drops the remainder
    exp8(25'h700, 32'h7766_5544, 8'h04);
    base = wr_cnt8;
    push8(32'h0000_0700, 32'h7766_5544, 8'h04);
    n = 0;
    while (wr_cnt8 < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("t6_wait_beat2");
    @(negedge clk);
    rst = 1'b1;
    q8.delete();
    repeat (2) @(negedge clk);
    check_reset8("t6_rst");
    rst = 1'b0;
    p = wr_cnt8;
    repeat (30) @(negedge clk);
    chk("t6_no_wr_after_rst", 32'(wr_cnt8), 32'(p));
    exp8(25'h800, 32'hA3A2_A1A0, 8'h05);
    push8(32'h0000_0800, 32'hA3A2_A1A0, 8'h05);
    drain8("t6_drain");
    chk("t6_beats_after_rst", 32'(wr_cnt8 - p), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
